// File: rtl/ser_port_pkg.sv
// ser_port_pkg: shared definitions for the ser_port_seq serial port sequencer.
//   - state_t       : serial engine FSM states
//   - REG_*         : register addresses inside the bus window
//   - BIT_*         : STATUS (read) / CTRL (write) bit positions
package ser_port_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [1:0] REG_STAT = 2'd0;
    localparam logic [1:0] REG_DATA = 2'd1;
    localparam logic [1:0] REG_DIV  = 2'd2;

    // STATUS read bits
    localparam int BIT_BUSY    = 0;
    localparam int BIT_DONE    = 1;
    // CTRL write bits (irq_en and keep_cs also read back in STATUS)
    localparam int BIT_CS_CLR  = 0;
    localparam int BIT_IRQ_EN  = 6;
    localparam int BIT_KEEP_CS = 7;

endpackage

// File: rtl/ser_port_clkdiv.sv
// ser_port_clkdiv: half-period counter for the serial clock.
//   clk   : system clock
//   rst   : synchronous reset, active-high
//   clear : restart the count from 0 (start of a transfer)
//   div   : terminal count; one half-period lasts div+1 cycles
//   tick  : high in the last cycle of each half-period (count == div)
module ser_port_clkdiv #(
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    assign tick = (cnt == div);

    always_ff @(posedge clk) begin
        if (rst || clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/ser_port_seq.sv
// ser_port_seq: bus-mapped sequencer for one bit-serial peripheral port.
// Shifts DATA_W bits MSB-first on sdo while capturing sdi, framed by scs.
//
// Ports:
//   clk, rst          : system clock, synchronous active-high reset
//   bus_sel           : access strobe (already window-decoded)
//   bus_addr          : 0 STATUS/CTRL, 1 DATA, 2 DIV, 3 reserved (reads 0)
//   bus_rw            : 1 read, 0 write
//   bus_wdata         : write data
//   bus_rdata         : combinational read data, 0 unless bus_sel & bus_rw
//   bus_rdy           : low only for a DATA write while a transfer runs
//   scs, sclk, sdo    : chip select (active-high), serial clock, data out
//   sdi               : serial data in
//   busy              : transfer in progress
//   irq               : done interrupt (only when SER_PORT_IRQ_EN is defined)
//
// Optional feature macro: SER_PORT_IRQ_EN adds irq and the CTRL/STATUS irq_en bit.
module ser_port_seq
    import ser_port_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bus_sel,
    input  logic [1:0]        bus_addr,
    input  logic              bus_rw,
    input  logic [DATA_W-1:0] bus_wdata,
    output logic [DATA_W-1:0] bus_rdata,
    output logic              bus_rdy,
    output logic              scs,
    output logic              sclk,
    output logic              sdo,
    input  logic              sdi,
    output logic              busy
`ifdef SER_PORT_IRQ_EN
    ,
    output logic              irq
`endif
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  shift_q;
    logic [DATA_W-1:0]  rx_q;
    logic [DIV_W-1:0]   div_q;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic               cap_q;
    logic               scs_q;
    logic               keep_cs_q;
    logic               done_q;
    logic               tick;
    logic               last_bit;
    logic               done_set;
    logic               irq_en_rd;

    logic wr_acc, rd_acc, data_wr, ctrl_wr, div_wr, data_rd;

    // Bus decode
    assign busy    = (state_q != IDLE);
    assign bus_rdy = ~(bus_sel & ~bus_rw & (bus_addr == REG_DATA) & busy);
    assign wr_acc  = bus_sel & ~bus_rw & bus_rdy;
    assign rd_acc  = bus_sel & bus_rw;
    // bus_rdy already holds off DATA writes while busy, so this only fires in IDLE
    assign data_wr = wr_acc & (bus_addr == REG_DATA);
    assign ctrl_wr = wr_acc & (bus_addr == REG_STAT);
    assign div_wr  = wr_acc & (bus_addr == REG_DIV) & ~busy;
    assign data_rd = rd_acc & (bus_addr == REG_DATA);

    assign last_bit = (bit_cnt_q == CNT_W'(DATA_W - 1));
    assign done_set = (state_q == HOLD) & tick;

    // Serial outputs decoded from the registered state
    assign scs  = scs_q;
    assign sclk = (state_q == HIGH);
    assign sdo  = ((state_q == LOW) || (state_q == HIGH)) & shift_q[DATA_W-1];

    ser_port_clkdiv #(.DIV_W(DIV_W)) u_clkdiv (
        .clk   (clk),
        .rst   (rst),
        .clear (data_wr),
        .div   (div_q),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (data_wr) state_d = LOW;
            LOW:     if (tick)    state_d = HIGH;
            HIGH:    if (tick)    state_d = last_bit ? HOLD : LOW;
            HOLD:    if (tick)    state_d = IDLE;
            default:              state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q   <= '0;
            rx_q      <= '0;
            div_q     <= '0;
            bit_cnt_q <= '0;
            cap_q     <= 1'b0;
            scs_q     <= 1'b0;
            keep_cs_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (data_wr) begin
                        shift_q   <= bus_wdata;
                        bit_cnt_q <= '0;
                        scs_q     <= 1'b1;
                    end else if (ctrl_wr && bus_wdata[BIT_CS_CLR]) begin
                        scs_q     <= 1'b0;
                    end
                end
                LOW: begin
                    // sdi is sampled as sclk is about to rise
                    if (tick) cap_q <= sdi;
                end
                HIGH: begin
                    if (tick) begin
                        shift_q <= {shift_q[DATA_W-2:0], cap_q};
                        if (!last_bit) bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (tick) begin
                        rx_q  <= shift_q;
                        scs_q <= keep_cs_q;
                    end
                end
                default: ;
            endcase

            if (ctrl_wr) keep_cs_q <= bus_wdata[BIT_KEEP_CS];
            if (div_wr)  div_q     <= bus_wdata[DIV_W-1:0];

            // A completing transfer beats a simultaneous DATA read
            if (done_set)     done_q <= 1'b1;
            else if (data_rd) done_q <= 1'b0;
        end
    end

`ifdef SER_PORT_IRQ_EN
    logic irq_en_q;
    logic irq_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (ctrl_wr) irq_en_q <= bus_wdata[BIT_IRQ_EN];
            if (done_set)     irq_q <= irq_q | irq_en_q;
            else if (data_rd) irq_q <= 1'b0;
        end
    end

    assign irq       = irq_q;
    assign irq_en_rd = irq_en_q;
`else
    assign irq_en_rd = 1'b0;
`endif

    always_comb begin
        bus_rdata = '0;
        if (rd_acc) begin
            case (bus_addr)
                REG_STAT: begin
                    bus_rdata[BIT_BUSY]    = busy;
                    bus_rdata[BIT_DONE]    = done_q;
                    bus_rdata[BIT_IRQ_EN]  = irq_en_rd;
                    bus_rdata[BIT_KEEP_CS] = keep_cs_q;
                end
                REG_DATA: bus_rdata = rx_q;
                REG_DIV:  bus_rdata[DIV_W-1:0] = div_q;
                default:  bus_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_ser_port_seq.sv
// tb_ser_port_seq: self-checking bench for ser_port_seq (DATA_W=8, DIV_W=4).
// Register access vectors from a table, then transfer-level checks of the
// serial waveform against expectations computed from the transfer rules.
module tb_ser_port_seq;

    localparam int DATA_W = 8;
    localparam int DIV_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              bus_sel;
    logic [1:0]        bus_addr;
    logic              bus_rw;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_rdy;
    logic              scs, sclk, sdo, sdi, busy;
    logic              sdi_drv;
    logic              loop_mode;
`ifdef SER_PORT_IRQ_EN
    logic              irq;
    localparam logic [7:0] IRQ_BIT = 8'h40;
`else
    localparam logic [7:0] IRQ_BIT = 8'h00;
`endif

    assign sdi = loop_mode ? sdo : sdi_drv;

    always #5 clk = ~clk;

    ser_port_seq #(.DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus_sel   (bus_sel),
        .bus_addr  (bus_addr),
        .bus_rw    (bus_rw),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_rdy   (bus_rdy),
        .scs       (scs),
        .sclk      (sclk),
        .sdo       (sdo),
        .sdi       (sdi),
        .busy      (busy)
`ifdef SER_PORT_IRQ_EN
        ,
        .irq       (irq)
`endif
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       sel;
        logic       rw;
        logic [1:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rd;
        logic       exp_rdy;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus_sel   = 1'b0;
        bus_rw    = 1'b1;
        bus_addr  = 2'd0;
        bus_wdata = '0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        bus_sel = 1'b1; bus_rw = 1'b0; bus_addr = a; bus_wdata = d;
        #1;
        step();
        idle_bus();
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        bus_sel = 1'b1; bus_rw = 1'b1; bus_addr = a;
        #1;
        d = bus_rdata;
        step();
        idle_bus();
    endtask

    task automatic start_xfer(input logic [7:0] tx, input string tag);
        bus_sel = 1'b1; bus_rw = 1'b0; bus_addr = 2'd1; bus_wdata = tx;
        #1;
        check({tag, "_start_rdy"}, bus_rdy, 1);
        step();
        idle_bus();
    endtask

    // Watches one transfer that was accepted on the previous edge, checks its
    // waveform, then reads STATUS, DATA and STATUS again.
    task automatic monitor(input logic [7:0] tx, input logic [7:0] rxw, input int div,
                           input logic keep, input string tag);
        int         busy_cnt  = 0;
        int         rises     = 0;
        int         hi_len    = 0;
        int         hi_bad    = 0;
        int         per_bad   = 0;
        int         scs_bad   = 0;
        int         last_rise = -1;
        logic       prev_sclk = 1'b0;
        logic       finished  = 1'b0;
        logic       scs_end   = 1'b0;
        logic [7:0] sdo_seq   = 8'h00;
        logic [7:0] d;
        for (int cyc = 1; cyc <= 4000; cyc++) begin
            #1;
            if (!busy) begin
                finished = 1'b1;
                scs_end  = scs;
                break;
            end
            busy_cnt++;
            if (!scs) scs_bad++;
            if (sclk && !prev_sclk) begin
                if (rises < 8) sdo_seq[7-rises] = sdo;
                if (last_rise >= 0 && (cyc - last_rise) != 2 * (div + 1)) per_bad++;
                last_rise = cyc;
                rises++;
                hi_len = 0;
            end
            if (sclk) hi_len++;
            if (!sclk && prev_sclk && hi_len != div + 1) hi_bad++;
            prev_sclk = sclk;
            if (!loop_mode) sdi_drv = (rises < 8) ? rxw[7-rises] : 1'b0;
            step();
        end
        check({tag, "_finished"}, finished, 1);
        check({tag, "_busy_cycles"}, busy_cnt, 17 * (div + 1));
        check({tag, "_sclk_rises"}, rises, 8);
        check({tag, "_sdo_bits"}, sdo_seq, tx);
        check({tag, "_sclk_high_len_errs"}, hi_bad, 0);
        check({tag, "_sclk_period_errs"}, per_bad, 0);
        check({tag, "_scs_low_while_busy"}, scs_bad, 0);
        check({tag, "_scs_after"}, scs_end, keep);
        step();
        bus_read(2'd0, d);
        check({tag, "_status_done"}, d, {keep, 7'b0} | 8'h02);
        bus_read(2'd1, d);
        check({tag, "_data"}, d, rxw);
        bus_read(2'd0, d);
        check({tag, "_status_cleared"}, d, {keep, 7'b0});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic       flag;
        int         cnt_a, cnt_b;

        // {sel, rw, addr, wdata, expected rdata, expected rdy}
        vecs.push_back('{1'b1, 1'b1, 2'd0, 8'h00, 8'h00, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 2'd2, 8'h05, 8'h00, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 2'd2, 8'h00, 8'h05, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 2'd2, 8'hF7, 8'h00, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 2'd2, 8'h00, 8'h07, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 2'd2, 8'h00, 8'h00, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 2'd3, 8'h00, 8'h00, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 2'd3, 8'hFF, 8'h00, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 2'd3, 8'h00, 8'h00, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 2'd0, 8'h80, 8'h00, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 2'd0, 8'h00, 8'h80, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 2'd0, 8'h40, 8'h00, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 2'd0, 8'h00, IRQ_BIT, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 2'd0, 8'h00, 8'h00, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 2'd2, 8'h00, 8'h00, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 2'd2, 8'h00, 8'h00, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 2'd1, 8'h00, 8'h00, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 2'd1, 8'h55, 8'h00, 1'b1});

        rst = 1'b1; loop_mode = 1'b0; sdi_drv = 1'b0;
        idle_bus();
        repeat (3) step();
        rst = 1'b0;
        #1;
        check("reset_scs", scs, 0);
        check("reset_sclk", sclk, 0);
        check("reset_sdo", sdo, 0);
        check("reset_busy", busy, 0);

        // Register access table
        foreach (vecs[i]) begin
            bus_sel = vecs[i].sel; bus_rw = vecs[i].rw;
            bus_addr = vecs[i].addr; bus_wdata = vecs[i].wdata;
            #1;
            check($sformatf("vec%0d_rdata", i), bus_rdata, vecs[i].exp_rd);
            check($sformatf("vec%0d_rdy", i), bus_rdy, vecs[i].exp_rdy);
            step();
        end
        idle_bus();
        #1;
        check("unselected_write_no_start", busy, 0);
        step();

        // Loopback, DIV=0
        loop_mode = 1'b1;
        start_xfer(8'hA5, "loop");
        monitor(8'hA5, 8'hA5, 0, 1'b0, "loop");
        loop_mode = 1'b0;

        // DIV=3, sdi held high
        bus_write(2'd2, 8'd3);
        start_xfer(8'h3C, "div3");
        monitor(8'h3C, 8'hFF, 3, 1'b0, "div3");

        // Randomized transfers
        for (int n = 0; n < 10; n++) begin
            logic [7:0] tx, rx;
            int         dv;
            logic       kp;
            tx = 8'($urandom);
            rx = 8'($urandom);
            dv = int'($urandom_range(0, 3));
            kp = 1'($urandom_range(0, 1));
            bus_write(2'd0, {kp, 7'b0});
            bus_write(2'd2, 8'(dv));
            start_xfer(tx, $sformatf("rnd%0d", n));
            monitor(tx, rx, dv, kp, $sformatf("rnd%0d", n));
        end

        // Register guards while busy
        sdi_drv = 1'b1;
        bus_write(2'd2, 8'd2);
        bus_write(2'd0, 8'h80);
        start_xfer(8'h96, "guard");
        bus_sel = 1'b1; bus_rw = 1'b0; bus_addr = 2'd2; bus_wdata = 8'd5;
        #1;
        check("guard_div_wr_rdy", bus_rdy, 1);
        step();
        idle_bus();
        bus_read(2'd2, d);
        check("guard_div_unchanged", d, 8'd2);
        bus_write(2'd0, 8'h81);
        #1;
        check("guard_cs_clr_ignored", scs, 1);
        bus_read(2'd3, d);
        check("guard_addr3", d, 8'h00);
        bus_read(2'd0, d);
        check("guard_status_busy", d, 8'h81);
        flag = 1'b0;
        for (int i = 0; i < 400; i++) begin
            #1;
            if (!busy) begin flag = 1'b1; break; end
            step();
        end
        check("guard_wait_idle", flag, 1);
        step();
        check("guard_keep_scs", scs, 1);
        bus_write(2'd0, 8'h01);
        #1;
        check("guard_cs_clr_idle", scs, 0);
        bus_read(2'd1, d);
        check("guard_data", d, 8'hFF);

        // DATA read in the same cycle the transfer completes
        sdi_drv = 1'b0;
        bus_write(2'd2, 8'd0);
        start_xfer(8'h3C, "coll");
        repeat (16) step();
        #1;
        check("coll_last_busy", busy, 1);
        bus_read(2'd1, d);
        check("coll_old_data", d, 8'hFF);
        bus_read(2'd0, d);
        check("coll_done_kept", d, 8'h02);
        bus_read(2'd1, d);
        check("coll_new_data", d, 8'h00);
        bus_read(2'd0, d);
        check("coll_done_cleared", d, 8'h00);

        // Stalled DATA write, keep_cs=1
        bus_write(2'd0, 8'h80);
        bus_write(2'd2, 8'd1);
        start_xfer(8'h12, "stall1");
        bus_sel = 1'b1; bus_rw = 1'b0; bus_addr = 2'd1; bus_wdata = 8'h81;
        cnt_a = 0; cnt_b = 0; flag = 1'b0;
        for (int i = 0; i < 400; i++) begin
            #1;
            if (busy) begin
                cnt_a++;
                if (bus_rdy) cnt_b++;
                if (!scs) cnt_b++;
                step();
            end else begin
                flag = 1'b1;
                check("stall_rdy_first_idle", bus_rdy, 1);
                check("stall_gap_scs", scs, 1);
                step();
                break;
            end
        end
        idle_bus();
        check("stall_accepted", flag, 1);
        check("stall_busy_cycles", cnt_a, 34);
        check("stall_rdy_or_scs_errs", cnt_b, 0);
        monitor(8'h81, 8'hC3, 1, 1'b1, "stall2");

        // Reset on cycle 5 of a DIV=0 transfer
        bus_write(2'd2, 8'd0);
        start_xfer(8'h5A, "rst");
        repeat (4) step();
        rst = 1'b1;
        step();
        #1;
        check("midrst_scs", scs, 0);
        check("midrst_sclk", sclk, 0);
        check("midrst_busy", busy, 0);
        rst = 1'b0;
        bus_read(2'd0, d);
        check("midrst_status", d, 8'h00);
        bus_read(2'd1, d);
        check("midrst_data", d, 8'h00);

`ifdef SER_PORT_IRQ_EN
        // irq with irq_en=1, then with irq_en=0
        loop_mode = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            logic en;
            en = (pass == 0);
            bus_write(2'd0, {1'b0, en, 6'b0});
            start_xfer(8'h55, "irq");
            cnt_a = 0; flag = 1'b0;
            for (int i = 0; i < 400; i++) begin
                #1;
                if (!busy) begin flag = 1'b1; break; end
                if (irq) cnt_a++;
                step();
            end
            check($sformatf("irq%0d_finished", pass), flag, 1);
            check($sformatf("irq%0d_early", pass), cnt_a, 0);
            check($sformatf("irq%0d_with_done", pass), irq, en);
            step();
            bus_read(2'd0, d);
            check($sformatf("irq%0d_status", pass), d, {1'b0, en, 6'b000010});
            bus_read(2'd1, d);
            check($sformatf("irq%0d_data", pass), d, 8'h55);
            #1;
            check($sformatf("irq%0d_cleared", pass), irq, 0);
        end
        loop_mode = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ser_port_seq.md
Name: ser_port_seq

Overview:
- Bus-mapped sequencer for a single bit-serial peripheral port (serial memory, shift-register I/O).
- CPU writes a byte into DATA. The block generates chip select, serial clock and data-out, shifts DATA_W bits MSB-first, and captures returning serial data.
- Sits behind the existing address-window decode (bus_sel already qualified by the upper address bits).
- Owns the serial engine. It is the only driver of scs/sclk/sdo.

Parameters:
- DATA_W, 8: bits per transfer.
- DIV_W, 4: width of the clock-divider register. Each sclk half-period is DIV+1 clk cycles.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- bus_sel  in  1  access strobe, already decoded for this block's window.
- bus_addr  in  2  register select: 0=STATUS/CTRL, 1=DATA, 2=DIV, 3=reserved.
- bus_rw  in  1  1=read, 0=write.
- bus_wdata  in  DATA_W  write data.
- bus_rdata  out  DATA_W  read data.
- bus_rdy  out  1  access completes this cycle; low inserts wait states.
- scs  out  1  peripheral chip select, active-high.
- sclk  out  1  serial clock; idles low.
- sdo  out  1  serial data out.
- sdi  in  1  serial data in.
- busy  out  1  transfer in progress.

Behaviour:
- Reset state: scs=0, sclk=0, sdo=0, busy=0, shift/DATA=0, DIV=0, keep_cs=0, done=0, FSM=IDLE.
- rst mid-transfer aborts immediately. No partial data is retained.
- bus_rdata is combinational from registers, valid while bus_sel & bus_rw. Value is 0 when bus_sel=0.
  - STATUS: bit0 busy, bit1 done, bit7 keep_cs, other bits 0.
  - Address 3 reads 0.
- Writes take effect only when bus_sel & ~bus_rw & bus_rdy.
- bus_rdy = ~(bus_sel & ~bus_rw & bus_addr==1 & busy). Only a DATA write during a transfer stalls; every other access has zero wait states.
- CTRL write:
  - bit7 loads keep_cs.
  - bit0=1 while idle forces scs=0 on the next cycle; ignored while busy.
- DIV write while busy is ignored.
- DATA read returns the last received word and clears done. A DATA read and a transfer completing in the same cycle leaves done=1 (set wins).
- FSM states:
  - IDLE: on an accepted DATA write, load the shift register, clear the bit count, clear the divider counter; next cycle goes to LOW with scs=1, busy=1.
  - LOW: sclk=0, sdo=shift MSB. Stays DIV+1 cycles, then goes to HIGH. On that transition sdi is sampled into a capture bit.
  - HIGH: sclk=1. Stays DIV+1 cycles.
    - If bit count = DATA_W-1: shift left with the capture bit into the LSB, then go to HOLD.
    - Otherwise: shift left, increment the count, go to LOW.
  - HOLD: sclk=0. Stays DIV+1 cycles, then goes to IDLE. DATA takes the shift value and done=1. scs drops to 0 unless keep_cs=1.
- Timing:
  - busy high for exactly (2*DATA_W+1)*(DIV+1) cycles, starting the cycle after the accepting write.
  - A stalled DATA write is accepted in the first IDLE cycle, so back-to-back transfers have one idle cycle between them. scs stays high across the gap when keep_cs=1.
- Divider counter wraps 0..DIV. With DIV=0, every state lasts 1 cycle.

Optional Feature:
- Macro SER_PORT_IRQ_EN.
- When defined:
  - Adds output irq (1 bit, reset 0).
  - irq asserts the cycle done sets, provided CTRL bit6 (irq_en, reset 0) is 1.
  - irq clears with done.
  - STATUS bit6 reads irq_en.
- When undefined: no irq port, CTRL bit6 is ignored, STATUS bit6 reads 0.

Decomposition:
- Package ser_port_pkg holds:
  - FSM state enum (IDLE, LOW, HIGH, HOLD).
  - Register address constants (REG_STAT=0, REG_DATA=1, REG_DIV=2).
  - STATUS/CTRL bit-position constants.
- One sub-module, ser_port_clkdiv: half-period counter with inputs clear and div value, output tick on count==DIV.

Test Plan:
- Loopback, DIV=0: tie sdi=sdo, write DATA=0xA5 -> busy high 17 cycles, 8 sclk pulses each 1 cycle high, DATA read=0xA5, done=1 before the read and 0 after.
- Divider, DIV=3: write 0x3C with sdi=1 -> sclk period 8 clk, busy 68 cycles, DATA=0xFF, sdo sequence 0,0,1,1,1,1,0,0 sampled at sclk rise.
- Stall: during a transfer, write DATA=0x81 -> bus_rdy=0 until the first IDLE cycle, then accepted; with keep_cs=1, scs never drops between the transfers.
- Reset mid-transfer: assert rst on cycle 5 of a DIV=0 transfer -> next cycle scs=0, sclk=0, busy=0, STATUS=0x00, DATA=0x00.
- Register guards: write DIV=5 while busy -> DIV read stays old value; CTRL bit0 while busy leaves scs=1; address 3 reads 0x00.
- IRQ (SER_PORT_IRQ_EN): irq_en=1, transfer 0x55 -> irq rises with done, clears on the DATA read; with irq_en=0, irq stays 0.
